// File: rtl/id_ex_stage_reg_pkg.sv
// Shared MIPS pipeline definitions: widths, ALU/opcode constants, the control
// word layout and the bubble (NOP) values used by every pipeline register.
package id_ex_stage_reg_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int FUNCT_W    = 6;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0]     pc_plus4;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [FUNCT_W-1:0]    funct;
  } data_t;

  typedef struct packed {
    logic  valid;
    ctrl_t ctrl;
    data_t data;
  } stage_t;

  // Bubble control word: no register/memory write, no branch, neutral ALU op.
  localparam ctrl_t CTRL_NOP = '{reg_dst: 1'b0, alu_src: 1'b0, mem_read: 1'b0,
                                 mem_write: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0,
                                 branch: 1'b0, alu_op: ALU_OP_ADD};

  localparam data_t DATA_NOP = '{pc_plus4: 32'h0, rs_data: 32'h0, rt_data: 32'h0,
                                 imm: 32'h0, rs: 5'd0, rt: 5'd0, rd: 5'd0, funct: 6'd0};

  localparam stage_t STAGE_NOP = '{valid: 1'b0, ctrl: CTRL_NOP, data: DATA_NOP};

  // rt is a true source operand unless the instruction uses the immediate as
  // its second ALU input and neither stores rt nor compares it in a branch.
  function automatic logic uses_rt(input logic alu_src, input logic mem_write,
                                   input logic branch);
    return (~alu_src) | mem_write | branch;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Combinational load-use hazard detector: an EX-stage load whose destination
// (rt, never $0) is read by the instruction currently in ID.
module hazard_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  output logic                  hz_o
);

  logic load_in_ex_s;
  logic rs_match_s;
  logic rt_match_s;

  assign load_in_ex_s = ex_valid_i & ex_mem_read_i & (ex_rt_i != 5'd0);
  assign rs_match_s   = (ex_rt_i == id_rs_i);
  assign rt_match_s   = (ex_rt_i == id_rt_i) & id_uses_rt_i;
  assign hz_o         = load_in_ex_s & (rs_match_s | rt_match_s);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures the decoded instruction for EX, inserting
// a bubble on a taken-branch flush or a load-use hazard, and freezing on hold.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic                  id_reg_dst_i,
  input  logic                  id_alu_src_i,
  input  logic                  id_mem_read_i,
  input  logic                  id_mem_write_i,
  input  logic                  id_mem_to_reg_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_branch_i,
  input  logic [1:0]            id_alu_op_i,
  input  logic [DATA_W-1:0]     id_pc_plus4_i,
  input  logic [DATA_W-1:0]     id_rs_data_i,
  input  logic [DATA_W-1:0]     id_rt_data_i,
  input  logic [DATA_W-1:0]     id_imm_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic [FUNCT_W-1:0]    id_funct_i,
  output logic                  ex_reg_dst_o,
  output logic                  ex_alu_src_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_mem_to_reg_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_branch_o,
  output logic [1:0]            ex_alu_op_o,
  output logic [DATA_W-1:0]     ex_pc_plus4_o,
  output logic [DATA_W-1:0]     ex_rs_data_o,
  output logic [DATA_W-1:0]     ex_rt_data_o,
  output logic [DATA_W-1:0]     ex_imm_o,
  output logic [REG_ADDR_W-1:0] ex_rs_o,
  output logic [REG_ADDR_W-1:0] ex_rt_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [FUNCT_W-1:0]    ex_funct_o,
  output logic                  ex_valid_o,
  output logic                  stall_o
);

  stage_t stage_q;
  stage_t stage_d;
  stage_t id_stage_s;
  logic   hz_s;

  hazard_detect u_hazard_detect (
    .ex_valid_i    (stage_q.valid),
    .ex_mem_read_i (stage_q.ctrl.mem_read),
    .ex_rt_i       (stage_q.data.rt),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_uses_rt_i  (uses_rt(id_alu_src_i, id_mem_write_i, id_branch_i)),
    .hz_o          (hz_s)
  );

  assign id_stage_s = '{
    valid: 1'b1,
    ctrl:  '{reg_dst: id_reg_dst_i, alu_src: id_alu_src_i, mem_read: id_mem_read_i,
             mem_write: id_mem_write_i, mem_to_reg: id_mem_to_reg_i,
             reg_write: id_reg_write_i, branch: id_branch_i, alu_op: id_alu_op_i},
    data:  '{pc_plus4: id_pc_plus4_i, rs_data: id_rs_data_i, rt_data: id_rt_data_i,
             imm: id_imm_i, rs: id_rs_i, rt: id_rt_i, rd: id_rd_i, funct: id_funct_i}
  };

  // Next-state priority: hold > flush > load-use bubble > capture ID.
  always_comb begin
    stage_d = stage_q;
    if (hold_i) begin
      stage_d = stage_q;
    end else if (flush_i) begin
      stage_d = STAGE_NOP;
    end else if (hz_s) begin
      stage_d = STAGE_NOP;
    end else begin
      stage_d = id_stage_s;
    end
  end

  // Stage register; reset empties EX with a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= STAGE_NOP;
    end else begin
      stage_q <= stage_d;
    end
  end

  // A flush discards the dependent instruction, so it must not also freeze IF/ID.
  assign stall_o = hz_s & ~flush_i & ~hold_i;

  assign ex_valid_o      = stage_q.valid;
  assign ex_reg_dst_o    = stage_q.ctrl.reg_dst;
  assign ex_alu_src_o    = stage_q.ctrl.alu_src;
  assign ex_mem_read_o   = stage_q.ctrl.mem_read;
  assign ex_mem_write_o  = stage_q.ctrl.mem_write;
  assign ex_mem_to_reg_o = stage_q.ctrl.mem_to_reg;
  assign ex_reg_write_o  = stage_q.ctrl.reg_write;
  assign ex_branch_o     = stage_q.ctrl.branch;
  assign ex_alu_op_o     = stage_q.ctrl.alu_op;
  assign ex_pc_plus4_o   = stage_q.data.pc_plus4;
  assign ex_rs_data_o    = stage_q.data.rs_data;
  assign ex_rt_data_o    = stage_q.data.rt_data;
  assign ex_imm_o        = stage_q.data.imm;
  assign ex_rs_o         = stage_q.data.rs;
  assign ex_rt_o         = stage_q.data.rt;
  assign ex_rd_o         = stage_q.data.rd;
  assign ex_funct_o      = stage_q.data.funct;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg: reset, pass-through,
// load-use bubble, false-hazard cases, flush with hazard, hold, async reset.
module tb_id_ex_stage_reg;

  localparam int VW = 158;

  logic clk;
  logic rst_n;
  logic hold_i;
  logic flush_i;
  logic [VW-1:0] id_vec;
  logic [VW-1:0] ex_vec;

  logic        id_reg_dst_i, id_alu_src_i, id_mem_read_i, id_mem_write_i;
  logic        id_mem_to_reg_i, id_reg_write_i, id_branch_i;
  logic [1:0]  id_alu_op_i;
  logic [31:0] id_pc_plus4_i, id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic [5:0]  id_funct_i;

  logic        ex_reg_dst_o, ex_alu_src_o, ex_mem_read_o, ex_mem_write_o;
  logic        ex_mem_to_reg_o, ex_reg_write_o, ex_branch_o;
  logic [1:0]  ex_alu_op_o;
  logic [31:0] ex_pc_plus4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic [5:0]  ex_funct_o;
  logic        ex_valid_o;
  logic        stall_o;

  int n_vec;
  int n_miss;

  assign {id_reg_dst_i, id_alu_src_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i,
          id_reg_write_i, id_branch_i, id_alu_op_i, id_pc_plus4_i, id_rs_data_i,
          id_rt_data_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i, id_funct_i} = id_vec;

  assign ex_vec = {ex_reg_dst_o, ex_alu_src_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o,
                   ex_reg_write_o, ex_branch_o, ex_alu_op_o, ex_pc_plus4_o, ex_rs_data_o,
                   ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_funct_o};

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i),
    .id_reg_dst_i(id_reg_dst_i), .id_alu_src_i(id_alu_src_i),
    .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .id_mem_to_reg_i(id_mem_to_reg_i), .id_reg_write_i(id_reg_write_i),
    .id_branch_i(id_branch_i), .id_alu_op_i(id_alu_op_i),
    .id_pc_plus4_i(id_pc_plus4_i), .id_rs_data_i(id_rs_data_i),
    .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_funct_i(id_funct_i),
    .ex_reg_dst_o(ex_reg_dst_o), .ex_alu_src_o(ex_alu_src_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_branch_o(ex_branch_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_pc_plus4_o(ex_pc_plus4_o), .ex_rs_data_o(ex_rs_data_o),
    .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .ex_funct_o(ex_funct_o),
    .ex_valid_o(ex_valid_o), .stall_o(stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Field order: reg_dst alu_src mem_read mem_write mem_to_reg reg_write branch alu_op
  function automatic logic [VW-1:0] mk(input logic [6:0] ctl, input logic [1:0] aop,
                                       input logic [31:0] pc, input logic [31:0] rsd,
                                       input logic [31:0] rtd, input logic [31:0] imm,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {ctl, aop, pc, rsd, rtd, imm, rs, rt, rd, fn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [VW-1:0] v_add, v_lw2, v_lw0, v_use0, v_addi_nm, v_addi_rt, v_sw, v_or, v_dep;
  logic [VW-1:0] zero_v;

  initial begin
    n_vec = 0;
    n_miss = 0;
    zero_v = '0;
    // add $3,$1,$2 : reg_dst, reg_write, R-type
    v_add     = mk(7'b1000010, 2'b10, 32'h104, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd3, 6'h20);
    // lw $2,4($1) : alu_src, mem_read, mem_to_reg, reg_write
    v_lw2     = mk(7'b0110110, 2'b00, 32'h108, 32'h1000, 32'h0, 32'h4, 5'd1, 5'd2, 5'd0, 6'h04);
    // add $4,$2,$3 : depends on $2 through rs
    v_dep     = mk(7'b1000010, 2'b10, 32'h10C, 32'h0, 32'h9, 32'h0, 5'd2, 5'd3, 5'd4, 6'h20);
    v_lw0     = mk(7'b0110110, 2'b00, 32'h110, 32'h1000, 32'h0, 32'h8, 5'd1, 5'd0, 5'd0, 6'h08);
    v_use0    = mk(7'b1000010, 2'b10, 32'h114, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd6, 6'h20);
    // addi $5,$6,1 : neither rs nor rt equals 2
    v_addi_nm = mk(7'b0100010, 2'b11, 32'h118, 32'h3, 32'h0, 32'h1, 5'd6, 5'd5, 5'd0, 6'h01);
    // addi $2,$7,1 : rt matches but is a destination only
    v_addi_rt = mk(7'b0100010, 2'b11, 32'h11C, 32'h3, 32'h0, 32'h1, 5'd7, 5'd2, 5'd0, 6'h01);
    // sw $2,0($5) : rt is a store source
    v_sw      = mk(7'b0101000, 2'b00, 32'h120, 32'h40, 32'hAB, 32'h0, 5'd5, 5'd2, 5'd0, 6'h00);
    v_or      = mk(7'b1000010, 2'b10, 32'h124, 32'hF0, 32'h0F, 32'h0, 5'd8, 5'd9, 5'd10, 6'h25);

    rst_n = 1'b0; hold_i = 1'b0; flush_i = 1'b0; id_vec = v_add;
    #12;
    chk("rst_ex", ex_vec, zero_v);
    chk("rst_valid", VW'(ex_valid_o), VW'(1'b0));
    chk("rst_stall", VW'(stall_o), VW'(1'b0));
    @(negedge clk); rst_n = 1'b1;

    // Pass-through
    step();
    chk("pass_ex", ex_vec, v_add);
    chk("pass_valid", VW'(ex_valid_o), VW'(1'b1));
    chk("pass_stall", VW'(stall_o), VW'(1'b0));

    // Load-use
    id_vec = v_lw2; step();
    id_vec = v_dep; #1;
    chk("lu_stall", VW'(stall_o), VW'(1'b1));
    step();
    chk("lu_bubble", ex_vec, zero_v);
    chk("lu_bubble_v", VW'(ex_valid_o), VW'(1'b0));
    chk("lu_stall_off", VW'(stall_o), VW'(1'b0));
    step();
    chk("lu_dep_ex", ex_vec, v_dep);
    chk("lu_dep_v", VW'(ex_valid_o), VW'(1'b1));

    // lw $0 then use of $0
    id_vec = v_lw0; step();
    id_vec = v_use0; #1;
    chk("nf_r0", VW'(stall_o), VW'(1'b0));
    // lw $2 then unrelated addi
    id_vec = v_lw2; step();
    id_vec = v_addi_nm; #1;
    chk("nf_nomatch", VW'(stall_o), VW'(1'b0));
    // lw $2 then addi writing $2
    id_vec = v_lw2; step();
    id_vec = v_addi_rt; #1;
    chk("nf_rt_dst", VW'(stall_o), VW'(1'b0));
    step();
    chk("nf_rt_dst_ex", ex_vec, v_addi_rt);
    // lw $2 then sw $2 : rt is a real source
    id_vec = v_lw2; step();
    id_vec = v_sw; #1;
    chk("sw_stall", VW'(stall_o), VW'(1'b1));
    step(); step();
    chk("sw_ex", ex_vec, v_sw);

    // Flush coinciding with a hazard
    id_vec = v_lw2; step();
    id_vec = v_dep; flush_i = 1'b1; #1;
    chk("fl_stall", VW'(stall_o), VW'(1'b0));
    step();
    chk("fl_bubble", ex_vec, zero_v);
    chk("fl_bubble_v", VW'(ex_valid_o), VW'(1'b0));
    flush_i = 1'b0; id_vec = v_or; step();
    chk("fl_next", ex_vec, v_or);

    // Hold across a load-use window
    id_vec = v_lw2; step();
    id_vec = v_dep; hold_i = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall", VW'(stall_o), VW'(1'b0));
      step();
      chk("hold_ex", ex_vec, v_lw2);
    end
    hold_i = 1'b0; #1;
    chk("hold_rel_stall", VW'(stall_o), VW'(1'b1));
    step();
    chk("hold_bubble", ex_vec, zero_v);
    step();
    chk("hold_dep", ex_vec, v_dep);

    // Async reset mid-stall
    id_vec = v_lw2; step();
    id_vec = v_dep; #2;
    chk("pre_rst_stall", VW'(stall_o), VW'(1'b1));
    rst_n = 1'b0; #1;
    chk("arst_ex", ex_vec, zero_v);
    chk("arst_valid", VW'(ex_valid_o), VW'(1'b0));
    chk("arst_stall", VW'(stall_o), VW'(1'b0));
    @(negedge clk); rst_n = 1'b1; id_vec = v_add;
    step();
    chk("post_rst_ex", ex_vec, v_add);
    chk("post_rst_v", VW'(ex_valid_o), VW'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
